// File: rtl/sram_ctrl_if_gen_if.sv
// Host-side request/acknowledge bundle between the AHB-Lite slave front end
// and the SRAM control interface.
interface sram_ctrl_if_gen_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 19
);
   logic                  req;
   logic                  write;
   logic [2:0]            size;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ack;
   logic                  err;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;

   modport master (
      output req, write, size, addr, wdata,
      input  ack, err, rdata, busy
   );

   modport slave (
      input  req, write, size, addr, wdata,
      output ack, err, rdata, busy
   );
endinterface

// File: rtl/sram_ctrl_if_gen.sv
// Turns single req/ack transactions into byte-enabled LSRAM/uSRAM strobes,
// with configurable read latency and optional sub-word read lane alignment.
module sram_ctrl_if_gen #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 19,
   parameter int RD_LATENCY = 1,
   parameter int RD_ALIGN   = 0
) (
   input  logic                                        HCLK,
   input  logic                                        HRESET,
   sram_ctrl_if_gen_if.slave                           bus,
   input  logic                                        mem_busy,
   output logic                                        mem_ren,
   output logic                                        mem_wen,
   output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  mem_addr,
   output logic [DATA_WIDTH/8-1:0]                     mem_byteen,
   output logic [DATA_WIDTH-1:0]                       mem_wdata,
   input  logic [DATA_WIDTH-1:0]                       mem_rdata
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_ERR} state_t;

   state_t                state_reg, state_next;
   logic [2:0]            cnt_reg, cnt_next;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic [LB-1:0]         rd_base_reg;
   logic [LB-1:0]         rd_mask_reg;

   logic [LB-1:0]         size_mask;
   logic [LB-1:0]         lane_base;
   logic                  size_ok;
   logic                  legal;
   logic                  issue_wr;
   logic                  issue_rd;
   logic                  capture;
   logic [DATA_WIDTH-1:0] rd_shift;
   logic [DATA_WIDTH-1:0] rd_aligned;
   logic [DATA_WIDTH-1:0] rd_fmt;

   // size_mask marks the address bits that must be zero for this transfer size
   genvar gi;
   generate
      for (gi = 0; gi < LB; gi++) begin : g_mask
         assign size_mask[gi] = ({29'd0, bus.size} > 32'(gi));
      end
   endgenerate

   assign size_ok   = ({29'd0, bus.size} <= 32'(LB));
   assign legal     = size_ok && ((bus.addr[LB-1:0] & size_mask) == '0);
   assign lane_base = bus.addr[LB-1:0] & ~size_mask;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      issue_wr   = 1'b0;
      issue_rd   = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.req) begin
               if (!legal) begin
                  state_next = ST_ERR;
               end else if (!mem_busy) begin
                  if (bus.write) begin
                     issue_wr   = 1'b1;
                     state_next = ST_WR;
                  end else begin
                     issue_rd   = 1'b1;
                     cnt_next   = 3'(RD_LATENCY);
                     state_next = ST_RD;
                  end
               end
            end
         end
         ST_WR, ST_ERR: state_next = ST_IDLE;
         ST_RD: begin
            // counter==0 inside RD is the acknowledge substate
            if (cnt_reg == 3'd0) begin
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - 3'd1;
               capture  = (cnt_reg == 3'd1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 3'd0;
         rdata_reg   <= '0;
         rd_base_reg <= '0;
         rd_mask_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (issue_rd) begin
            rd_base_reg <= lane_base;
            rd_mask_reg <= size_mask;
         end
         if (capture) begin
            rdata_reg <= rd_fmt;
         end
      end
   end

   assign rd_shift = mem_rdata >> {rd_base_reg, 3'b000};

   generate
      for (gi = 0; gi < NB; gi++) begin : g_lanes
         assign mem_byteen[gi] = mem_wen && ((LB'(gi) & ~size_mask) == lane_base);
         assign rd_aligned[8*gi +: 8] =
            ((LB'(gi) & ~rd_mask_reg) == '0) ? rd_shift[8*gi +: 8] : 8'h00;
      end
   endgenerate

   assign rd_fmt = (RD_ALIGN != 0) ? rd_aligned : mem_rdata;

   // strobes and ack are held off while reset is asserted so an aborted
   // transaction never completes
   assign mem_wen   = issue_wr && !HRESET;
   assign mem_ren   = issue_rd && !HRESET;
   assign mem_addr  = bus.addr[ADDR_WIDTH-1:LB];
   assign mem_wdata = bus.wdata;

   assign bus.ack   = !HRESET && ((state_reg == ST_WR) || (state_reg == ST_ERR) ||
                                  ((state_reg == ST_RD) && (cnt_reg == 3'd0)));
   assign bus.err   = !HRESET && (state_reg == ST_ERR);
   assign bus.rdata = rdata_reg;
   assign bus.busy  = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_sram_ctrl_if_gen.sv
// Bench for sram_ctrl_if_gen: byte-addressed reference memory model with
// directed scenarios followed by randomized transactions.
module tb_sram_ctrl_if_gen;
   localparam int DW    = 32;
   localparam int AW    = 19;
   localparam int LAT   = 3;
   localparam int ALIGN = 1;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        mem_busy = 1'b0;
   logic        mem_load = 1'b1;
   logic        mem_ren, mem_wen;
   logic [16:0] mem_addr;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata, mem_rdata;

   always #5 HCLK = ~HCLK;

   sram_ctrl_if_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   sram_ctrl_if_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .RD_ALIGN(ALIGN)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .bus(bus), .mem_busy(mem_busy),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] init_word(input int i);
      return 32'h11223344 + 32'(i) * 32'h9E3779B9;
   endfunction

   // Memory array behind the controller; read data appears LAT cycles after
   // mem_ren and is garbage otherwise.
   logic [31:0]    mem_words [0:63];
   logic [31:0]    rd_pipe   [0:LAT-1];
   logic [LAT-1:0] rd_v;
   logic [31:0]    garbage;
   always @(posedge HCLK) begin
      if (mem_load) begin
         for (int i = 0; i < 64; i++) mem_words[i] <= init_word(i);
      end else if (mem_wen) begin
         for (int j = 0; j < 4; j++)
            if (mem_byteen[j]) mem_words[mem_addr[5:0]][8*j +: 8] <= mem_wdata[8*j +: 8];
      end
      rd_pipe[0] <= mem_words[mem_addr[5:0]];
      rd_v[0]    <= mem_ren;
      for (int k = 1; k < LAT; k++) begin
         rd_pipe[k] <= rd_pipe[k-1];
         rd_v[k]    <= rd_v[k-1];
      end
      garbage <= $urandom;
   end
   assign mem_rdata = rd_v[LAT-1] ? rd_pipe[LAT-1] : garbage;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_rdata;
   logic [7:0]  ref_bytes [0:255];

   int          s_cyc, a_cyc, n_str;
   logic        busy_e, err_o, wen_o, gap_a;
   logic [31:0] rd_o;
   logic [3:0]  be_o;
   logic [16:0] ma_o;

   function automatic bit is_legal(input logic [2:0] sz, input logic [18:0] a);
      return (sz <= 3'd2) && ((int'(a) % (1 << sz)) == 0);
   endfunction

   function automatic logic [3:0] exp_byteen(input logic [2:0] sz, input logic [18:0] a);
      int n = 1 << sz;
      int b = int'(a) % 4;
      logic [3:0] r = '0;
      for (int j = 0; j < 4; j++) if (j >= b && j < b + n) r[j] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [2:0] sz, input logic [18:0] a);
      logic [31:0] r = '0;
      for (int k = 0; k < (1 << sz); k++) r[8*k +: 8] = ref_bytes[int'(a) + k];
      return r;
   endfunction

   task automatic ref_write(input logic [2:0] sz, input logic [18:0] a, input logic [31:0] wd);
      for (int k = 0; k < (1 << sz); k++)
         ref_bytes[int'(a) + k] = wd[8*((int'(a) % 4) + k) +: 8];
   endtask

   // Drives one transaction and reports what was observed; cycle 0 is the
   // first cycle req is high.
   task automatic run_txn(input logic w, input logic [2:0] sz, input logic [18:0] a,
                          input logic [31:0] wd, input int busy_n);
      int cyc = 0;
      @(negedge HCLK);
      bus.req = 1'b1; bus.write = w; bus.size = sz; bus.addr = a; bus.wdata = wd;
      s_cyc = -1; a_cyc = -1; n_str = 0; busy_e = 1'b0; err_o = 1'b0;
      rd_o = '0; be_o = '0; ma_o = '0; wen_o = 1'b0;
      while (a_cyc < 0 && cyc < 40) begin
         mem_busy = (cyc < busy_n);
         #1;
         if (mem_wen || mem_ren) begin
            n_str++;
            if (s_cyc < 0) begin
               s_cyc = cyc; be_o = mem_byteen; ma_o = mem_addr; wen_o = mem_wen;
            end
         end
         if (cyc < busy_n && bus.busy) busy_e = 1'b1;
         if (bus.ack) begin
            a_cyc = cyc; err_o = bus.err; rd_o = bus.rdata;
         end
         @(negedge HCLK);
         cyc++;
      end
      bus.req = 1'b0; mem_busy = 1'b0;
      #1;
      gap_a = bus.ack;
      $display("txn %s size=%0d addr=%h wdata=%h busy_n=%0d strobe=%0d ack=%0d err=%b rdata=%h",
               w ? "WR" : "RD", sz, a, wd, busy_n, s_cyc, a_cyc, err_o, rd_o);
   endtask

   task automatic test_reset;
      HRESET = 1'b1; mem_load = 1'b1;
      bus.req = 1'b1; bus.write = 1'b1; bus.size = 3'd2; bus.addr = 19'h4; bus.wdata = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK); #1;
         checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
         checks++; if ((mem_wen | mem_ren) !== 1'b0) begin failures++; $display("FAIL reset_strobe: wen=%b ren=%b want 0", mem_wen, mem_ren); end
      end
      @(negedge HCLK);
      HRESET = 1'b0; mem_load = 1'b0; bus.req = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.ack !== 1'b0) begin failures++; $display("FAIL post_reset_ack: got %b want 0", bus.ack); end
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
      last_rdata = 32'h0;
      $display("txn RESET busy=%b ack=%b rdata=%h", bus.busy, bus.ack, bus.rdata);
   endtask

   task automatic test_write_word;
      run_txn(1'b1, 3'd2, 19'h4, 32'hA5A5A5A5, 0);
      checks++; if (s_cyc !== 0 || n_str !== 1 || wen_o !== 1'b1) begin failures++; $display("FAIL wr_strobe: cyc=%0d n=%0d wen=%b want 0/1/1", s_cyc, n_str, wen_o); end
      checks++; if (ma_o !== 17'h1) begin failures++; $display("FAIL wr_addr: got %h want 1", ma_o); end
      checks++; if (be_o !== 4'hF) begin failures++; $display("FAIL wr_byteen: got %b want 1111", be_o); end
      checks++; if (a_cyc !== 1 || err_o !== 1'b0) begin failures++; $display("FAIL wr_ack: cyc=%0d err=%b want 1/0", a_cyc, err_o); end
      checks++; if (gap_a !== 1'b0) begin failures++; $display("FAIL wr_gap: ack=%b want 0", gap_a); end
      ref_write(3'd2, 19'h4, 32'hA5A5A5A5);
   endtask

   task automatic test_sub_word;
      run_txn(1'b1, 3'd0, 19'h13, 32'h77000000, 0);
      checks++; if (be_o !== 4'b1000 || ma_o !== 17'h4) begin failures++; $display("FAIL byte_wr: be=%b addr=%h want 1000/4", be_o, ma_o); end
      ref_write(3'd0, 19'h13, 32'h77000000);
      run_txn(1'b1, 3'd1, 19'h12, 32'hBEEF0000, 0);
      checks++; if (be_o !== 4'b1100 || ma_o !== 17'h4) begin failures++; $display("FAIL half_wr: be=%b addr=%h want 1100/4", be_o, ma_o); end
      ref_write(3'd1, 19'h12, 32'hBEEF0000);
      run_txn(1'b0, 3'd2, 19'h10, 32'h0, 0);
      checks++; if (rd_o !== exp_rdata(3'd2, 19'h10)) begin failures++; $display("FAIL merge_rd: got %h want %h", rd_o, exp_rdata(3'd2, 19'h10)); end
      last_rdata = exp_rdata(3'd2, 19'h10);
   endtask

   task automatic test_read_align;
      run_txn(1'b0, 3'd1, 19'h2, 32'h0, 0);
      checks++; if (a_cyc !== s_cyc + LAT + 1 || s_cyc !== 0) begin failures++; $display("FAIL rd_latency: strobe=%0d ack=%0d want 0/%0d", s_cyc, a_cyc, LAT + 1); end
      checks++; if (rd_o !== 32'h00001122) begin failures++; $display("FAIL rd_align: got %h want 00001122", rd_o); end
      checks++; if (be_o !== 4'b0000) begin failures++; $display("FAIL rd_byteen: got %b want 0000", be_o); end
      run_txn(1'b0, 3'd0, 19'h3, 32'h0, 0);
      checks++; if (rd_o !== 32'h00000011) begin failures++; $display("FAIL rd_byte3: got %h want 00000011", rd_o); end
      last_rdata = 32'h00000011;
   endtask

   task automatic test_errors;
      logic [2:0]  sz [3];
      logic [18:0] ad [3];
      int          bn [3];
      sz = '{3'd3, 3'd1, 3'd2}; ad = '{19'h0, 19'h1, 19'h2}; bn = '{0, 0, 3};
      for (int i = 0; i < 3; i++) begin
         run_txn(1'b0, sz[i], ad[i], 32'h0, bn[i]);
         checks++; if (n_str !== 0) begin failures++; $display("FAIL err_strobe: got %0d strobes want 0", n_str); end
         checks++; if (a_cyc !== 1 || err_o !== 1'b1) begin failures++; $display("FAIL err_ack: cyc=%0d err=%b want 1/1", a_cyc, err_o); end
         checks++; if (rd_o !== last_rdata) begin failures++; $display("FAIL err_rdata: got %h want %h", rd_o, last_rdata); end
      end
   endtask

   task automatic test_mem_busy;
      run_txn(1'b1, 3'd2, 19'h20, 32'hCAFEF00D, 5);
      checks++; if (s_cyc !== 5 || n_str !== 1) begin failures++; $display("FAIL busy_strobe: cyc=%0d n=%0d want 5/1", s_cyc, n_str); end
      checks++; if (busy_e !== 1'b0) begin failures++; $display("FAIL busy_flag: got %b want 0", busy_e); end
      checks++; if (a_cyc !== 6) begin failures++; $display("FAIL busy_ack: got %0d want 6", a_cyc); end
      ref_write(3'd2, 19'h20, 32'hCAFEF00D);
      run_txn(1'b0, 3'd2, 19'h20, 32'h0, 2);
      checks++; if (s_cyc !== 2 || a_cyc !== 2 + LAT + 1 || rd_o !== 32'hCAFEF00D) begin failures++; $display("FAIL busy_rd: strobe=%0d ack=%0d rdata=%h want 2/%0d/cafef00d", s_cyc, a_cyc, rd_o, 3 + LAT); end
      last_rdata = 32'hCAFEF00D;
   endtask

   task automatic test_reset_mid_read;
      int acks = 0;
      @(negedge HCLK);
      bus.req = 1'b1; bus.write = 1'b0; bus.size = 3'd2; bus.addr = 19'h8;
      #1;
      checks++; if (mem_ren !== 1'b1) begin failures++; $display("FAIL abort_ren: got %b want 1", mem_ren); end
      @(negedge HCLK);
      bus.req = 1'b0;
      @(negedge HCLK);
      HRESET = 1'b1;
      #1;
      if (bus.ack) acks++;
      @(negedge HCLK);
      HRESET = 1'b0;
      for (int i = 0; i < LAT + 3; i++) begin
         #1;
         if (bus.ack) acks++;
         @(negedge HCLK);
      end
      #1;
      checks++; if (acks !== 0) begin failures++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
      checks++; if (bus.busy !== 1'b0 || bus.rdata !== 32'h0) begin failures++; $display("FAIL abort_state: busy=%b rdata=%h want 0/0", bus.busy, bus.rdata); end
      $display("txn ABORT_RD acks=%0d busy=%b rdata=%h", acks, bus.busy, bus.rdata);
      last_rdata = 32'h0;
      run_txn(1'b0, 3'd2, 19'h8, 32'h0, 0);
      checks++; if (a_cyc !== LAT + 1 || rd_o !== exp_rdata(3'd2, 19'h8)) begin failures++; $display("FAIL abort_next_rd: ack=%0d rdata=%h want %0d/%h", a_cyc, rd_o, LAT + 1, exp_rdata(3'd2, 19'h8)); end
      last_rdata = exp_rdata(3'd2, 19'h8);
   endtask

   task automatic test_random;
      for (int t = 0; t < 40; t++) begin
         logic        w;
         logic [2:0]  sz;
         logic [18:0] a;
         logic [31:0] wd, er;
         int          r, bn;
         w  = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 9);
         sz = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
         a  = 19'($urandom_range(0, 255));
         if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~19'((1 << sz) - 1);
         wd = $urandom;
         bn = $urandom_range(0, 2);
         run_txn(w, sz, a, wd, bn);
         checks++; if (gap_a !== 1'b0) begin failures++; $display("FAIL rnd_gap: ack=%b want 0", gap_a); end
         if (!is_legal(sz, a)) begin
            checks++; if (n_str !== 0 || a_cyc !== 1 || err_o !== 1'b1 || rd_o !== last_rdata) begin failures++; $display("FAIL rnd_err: n=%0d ack=%0d err=%b rdata=%h want 0/1/1/%h", n_str, a_cyc, err_o, rd_o, last_rdata); end
         end else begin
            checks++; if (s_cyc !== bn || n_str !== 1 || wen_o !== w || ma_o !== 17'(a >> 2) || busy_e !== 1'b0) begin failures++; $display("FAIL rnd_strobe: cyc=%0d n=%0d wen=%b addr=%h busy=%b want %0d/1/%b/%h/0", s_cyc, n_str, wen_o, ma_o, busy_e, bn, w, a >> 2); end
            checks++; if (a_cyc !== s_cyc + (w ? 1 : LAT + 1) || err_o !== 1'b0) begin failures++; $display("FAIL rnd_ack: cyc=%0d err=%b want %0d/0", a_cyc, err_o, s_cyc + (w ? 1 : LAT + 1)); end
            if (w) begin
               checks++; if (be_o !== exp_byteen(sz, a) || rd_o !== last_rdata) begin failures++; $display("FAIL rnd_wr: be=%b rdata=%h want %b/%h", be_o, rd_o, exp_byteen(sz, a), last_rdata); end
               ref_write(sz, a, wd);
            end else begin
               er = exp_rdata(sz, a);
               checks++; if (be_o !== 4'b0000 || rd_o !== er) begin failures++; $display("FAIL rnd_rd: be=%b rdata=%h want 0000/%h", be_o, rd_o, er); end
               last_rdata = er;
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = init_word(i) >> (8*j);
      bus.req = 1'b0; bus.write = 1'b0; bus.size = 3'd0; bus.addr = '0; bus.wdata = '0;
      test_reset();
      test_write_word();
      test_sub_word();
      test_read_align();
      test_errors();
      test_mem_busy();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
